// File: rtl/onehot_pulse_decoder_if.sv
// Code-request bus for onehot_pulse_decoder: valid/ready code input plus the timed strobe outputs.
interface onehot_pulse_decoder_if #(
  parameter int unsigned N_OUT = 12,
  parameter int unsigned IDX_W = 4
) ();
  logic             code_valid;
  logic [IDX_W-1:0] code;
  logic             code_ready;
  logic [N_OUT-1:0] onehot_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output code_valid, code,
    input  code_ready, onehot_out, busy, done, err
  );

  modport slave (
    input  code_valid, code,
    output code_ready, onehot_out, busy, done, err
  );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Index-to-one-hot strobe generator: fires the selected line for PULSE_CYCLES, then holds an
// all-low gap of GAP_CYCLES before signalling done and accepting the next code.
module onehot_pulse_decoder #(
  parameter int unsigned N_OUT        = 12,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input logic                  clock,
  input logic                  reset_n,
  onehot_pulse_decoder_if.slave bus
);

  localparam int unsigned CntMax = (PULSE_CYCLES > GAP_CYCLES) ?
                                   ((PULSE_CYCLES > 2) ? PULSE_CYCLES : 2) :
                                   ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPulse = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_OUT-1:0] onehot_q, onehot_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             code_legal;

  assign bus.code_ready = (state_q == StIdle) && reset_n;
  assign accept         = bus.code_valid && bus.code_ready;
  // Zero-extend so the compare is unsigned regardless of IDX_W.
  assign code_legal     = {{(32-IDX_W){1'b0}}, bus.code} < N_OUT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (code_legal) begin
            state_d  = StPulse;
            onehot_d = N_OUT'(1) << bus.code;
            cnt_d    = CntW'(PULSE_CYCLES - 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          onehot_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            cnt_d   = CntW'(GAP_CYCLES - 1);
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        onehot_d = '0;
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        onehot_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      onehot_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.onehot_out = onehot_q;
  assign bus.busy       = (state_q == StPulse) || (state_q == StGap);
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: default 4/2 build plus a 1/0 build for the short case.
module tb_onehot_pulse_decoder;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  onehot_pulse_decoder_if #(.N_OUT(12), .IDX_W(4)) bus ();
  onehot_pulse_decoder_if #(.N_OUT(12), .IDX_W(4)) bus2 ();

  onehot_pulse_decoder #(
    .N_OUT(12), .IDX_W(4), .PULSE_CYCLES(4), .GAP_CYCLES(2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  onehot_pulse_decoder #(
    .N_OUT(12), .IDX_W(4), .PULSE_CYCLES(1), .GAP_CYCLES(0)
  ) dut2 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to just after the next rising edge; all driving and sampling happen there.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.code_valid = 1'b1;
    bus.code = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.onehot_out !== 12'h000 || bus.code_ready !== 1'b0 || bus.done !== 1'b0 ||
          bus.err !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc%0d: onehot=%h ready=%b done=%b err=%b busy=%b want 000 0 0 0 0",
                 i, bus.onehot_out, bus.code_ready, bus.done, bus.err, bus.busy);
      end
    end
    bus.code_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    total++;
    if (bus.code_ready !== 1'b1 || bus2.code_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset release: ready=%b ready2=%b want 1 1", bus.code_ready,
               bus2.code_ready);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.onehot_out !== 12'h000 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset idle: busy=%b onehot=%h done=%b want 0 000 0", bus.busy,
               bus.onehot_out, bus.done);
    end
  endtask

  task automatic test_single_fire();
    bus.code = 4'd3;
    bus.code_valid = 1'b1;
    tick();  // accept edge k
    bus.code_valid = 1'b0;
    bus.code = 4'd9;  // must not disturb the latched request
    for (int c = 1; c <= 7; c++) begin
      logic [11:0] exp_oh;
      logic        exp_done;
      exp_oh   = (c <= 4) ? 12'h008 : 12'h000;
      exp_done = (c == 7);
      total++;
      if (bus.onehot_out !== exp_oh || bus.done !== exp_done || bus.code_ready !== exp_done ||
          bus.busy !== !exp_done || bus.err !== 1'b0) begin
        bad++;
        $display("FAIL single k+%0d: onehot=%h done=%b ready=%b busy=%b err=%b want %h %b %b %b 0",
                 c, bus.onehot_out, bus.done, bus.code_ready, bus.busy, bus.err, exp_oh,
                 exp_done, exp_done, !exp_done);
      end
      tick();
    end
    total++;
    if (bus.done !== 1'b0 || bus.onehot_out !== 12'h000) begin
      bad++;
      $display("FAIL single after: done=%b onehot=%h want 0 000", bus.done, bus.onehot_out);
    end
  endtask

  task automatic test_illegal(input logic [3:0] c);
    bus.code = c;
    bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
    total++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.onehot_out !== 12'h000 ||
        bus.code_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL illegal %0d: err=%b done=%b onehot=%h ready=%b busy=%b want 1 0 000 1 0",
               c, bus.err, bus.done, bus.onehot_out, bus.code_ready, bus.busy);
    end
    tick();
    total++;
    if (bus.err !== 1'b0 || bus.onehot_out !== 12'h000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL illegal %0d after: err=%b onehot=%h busy=%b want 0 000 0", c, bus.err,
               bus.onehot_out, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.code = 4'd11;
    bus.code_valid = 1'b1;
    tick();  // first accept at edge k
    bus.code = 4'd0;  // valid stays high through the busy period
    for (int c = 1; c <= 14; c++) begin
      logic [11:0] exp_oh;
      logic        exp_done;
      if (c <= 4) exp_oh = 12'h800;
      else if (c >= 8 && c <= 11) exp_oh = 12'h001;
      else exp_oh = 12'h000;
      exp_done = (c == 7) || (c == 14);
      total++;
      if (bus.onehot_out !== exp_oh || bus.done !== exp_done || bus.err !== 1'b0) begin
        bad++;
        $display("FAIL b2b k+%0d: onehot=%h done=%b err=%b want %h %b 0", c, bus.onehot_out,
                 bus.done, bus.err, exp_oh, exp_done);
      end
      if (c == 8) bus.code_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_abort();
    bus.code = 4'd7;
    bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
    tick();  // second PULSE cycle
    total++;
    if (bus.onehot_out !== 12'h080) begin
      bad++;
      $display("FAIL abort pre: onehot=%h want 080", bus.onehot_out);
    end
    reset_n = 1'b0;
    tick();
    total++;
    if (bus.onehot_out !== 12'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.code_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort edge: onehot=%h busy=%b done=%b ready=%b want 000 0 0 0",
               bus.onehot_out, bus.busy, bus.done, bus.code_ready);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (bus.onehot_out !== 12'h000 || bus.done !== 1'b0 || bus.busy !== 1'b0 ||
          bus.code_ready !== 1'b1) begin
        bad++;
        $display("FAIL abort after %0d: onehot=%h done=%b busy=%b ready=%b want 000 0 0 1", i,
                 bus.onehot_out, bus.done, bus.busy, bus.code_ready);
      end
    end
  endtask

  task automatic test_short_build();
    bus2.code = 4'd9;
    bus2.code_valid = 1'b1;
    tick();
    bus2.code_valid = 1'b0;
    total++;
    if (bus2.onehot_out !== 12'h200 || bus2.code_ready !== 1'b0 || bus2.done !== 1'b0) begin
      bad++;
      $display("FAIL short pulse: onehot=%h ready=%b done=%b want 200 0 0", bus2.onehot_out,
               bus2.code_ready, bus2.done);
    end
    tick();
    total++;
    if (bus2.onehot_out !== 12'h000 || bus2.done !== 1'b1 || bus2.code_ready !== 1'b1 ||
        bus2.busy !== 1'b0) begin
      bad++;
      $display("FAIL short done: onehot=%h done=%b ready=%b busy=%b want 000 1 1 0",
               bus2.onehot_out, bus2.done, bus2.code_ready, bus2.busy);
    end
    tick();
    total++;
    if (bus2.done !== 1'b0 || bus2.onehot_out !== 12'h000) begin
      bad++;
      $display("FAIL short after: done=%b onehot=%h want 0 000", bus2.done, bus2.onehot_out);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    bus.code_valid = 1'b0;
    bus.code = '0;
    bus2.code_valid = 1'b0;
    bus2.code = '0;
    test_reset();
    test_single_fire();
    test_illegal(4'd12);
    test_illegal(4'd15);
    test_back_to_back();
    test_reset_abort();
    test_short_build();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
